trainled_chain_ctrl: RTL and testbench

- Frame scheduler for two TrainLED2 daisy chains that share one serial bit encoder.
- Arbitrates frame requests from the two chains round-robin and pulls 24-bit node words from a host stream.
- Pulse-width encodes each word MSB first onto the granted chain's din line, then closes the frame with a latch gap.
- Sits between the host/register logic and the din inputs of the chain instances.

---
 rtl/trainled_pkg.sv | 33 +++
 rtl/trainled_chain_ctrl_bit_enc.sv | 47 ++++
 rtl/trainled_chain_ctrl.sv | 160 ++++++++++++++++
 tb/tb_trainled_chain_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trainled_pkg.sv
// trainled_pkg: shared types and default timing for the TrainLED2 chain
// controller.
//   state_t          frame FSM states
//   DEF_WORD_W       bits per node word (3 channels x 8 bits)
//   DEF_TBIT         clock cycles per encoded bit
//   DEF_T0H/DEF_T1H  high cycles for a '0' / '1' bit
//   DEF_TRES         latch gap length and LOAD underrun timeout
package trainled_pkg;

  localparam int unsigned DEF_WORD_W = 24;
  localparam int unsigned DEF_TBIT   = 16;
  localparam int unsigned DEF_T0H    = 4;
  localparam int unsigned DEF_T1H    = 12;
  localparam int unsigned DEF_TRES   = 256;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trainled_chain_ctrl_bit_enc.sv
// trainled_bit_enc: pulse-width encoder for one TrainLED2 bit.
//   clk, rst  clock / asynchronous active-low reset
//   start     launch a bit; the waveform begins the following cycle
//   bit_val   value of the bit being launched (sampled with start)
//   pulse     high for T1H (bit=1) or T0H (bit=0) cycles of the TBIT-cycle slot
//   done      high in the last cycle of the slot; start may be asserted in the
//             same cycle to chain the next bit without a gap
module trainled_bit_enc
  import trainled_pkg::*;
#(
  parameter int unsigned TBIT = DEF_TBIT,
  parameter int unsigned T0H  = DEF_T0H,
  parameter int unsigned T1H  = DEF_T1H
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic pulse,
  output logic done
);

  localparam int unsigned CW = cnt_width(TBIT);

  logic [CW-1:0] cnt;
  logic          active;
  logic          bit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      active <= 1'b0;
      bit_q  <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
      bit_q  <= bit_val;
    end else if (active) begin
      if (cnt == CW'(TBIT - 1)) active <= 1'b0;
      else                      cnt    <= cnt + 1'b1;
    end
  end

  assign pulse = active && (cnt < (bit_q ? CW'(T1H) : CW'(T0H)));
  assign done  = active && (cnt == CW'(TBIT - 1));

endmodule

// File: rtl/trainled_chain_ctrl.sv
// trainled_chain_ctrl: frame scheduler for two TrainLED2 daisy chains sharing
// one serial bit encoder. Round-robin arbitration, 24-bit word fetch from a
// valid/ready host stream, MSB-first pulse-width encoding, latch gap.
//   clk, rst         clock / asynchronous active-low reset
//   req[1:0]         per-chain frame request (level)
//   grant[1:0]       one-hot encoder owner, 0 when idle
//   data, data_last  node word and end-of-frame flag, qualified by data_valid
//   data_ready       high in LOAD only
//   dout[1:0]        serial din lines; the non-granted line is always 0
//   busy             FSM not in IDLE
//   underrun         one-cycle pulse (first LATCH cycle) on a timed-out LOAD
//   frame_cnt        per-chain completed frame counters, only with
//                    TRAINLED_FRAME_CNT_EN defined
module trainled_chain_ctrl
  import trainled_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned TBIT   = DEF_TBIT,
  parameter int unsigned T0H    = DEF_T0H,
  parameter int unsigned T1H    = DEF_T1H,
  parameter int unsigned TRES   = DEF_TRES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        grant,
  input  logic [WORD_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              data_last,
  output logic [1:0]        dout,
  output logic              busy,
  output logic              underrun
`ifdef TRAINLED_FRAME_CNT_EN
  ,
  output logic [1:0][15:0]  frame_cnt
`endif
);

  localparam int unsigned TMR_W = cnt_width(max_u(TBIT, TRES));
  localparam int unsigned BIX_W = cnt_width(WORD_W);

  state_t            state, state_nxt;
  logic [1:0]        req_q;
  logic              last_srv;
  logic [WORD_W-1:0] word_q;
  logic              last_q;
  logic [BIX_W-1:0]  bit_idx;
  logic [TMR_W-1:0]  tmr;
  logic              underrun_q;

  logic winner, hs, load_timeout, latch_done, last_bit, bit_adv;
  logic enc_start, enc_bit, enc_pulse, enc_done;

  always_comb begin
    winner = 1'b0;
    case (req_q)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_srv;
      default: winner = 1'b0;
    endcase
  end

  assign hs           = (state == LOAD) && data_valid;
  assign load_timeout = (state == LOAD) && !data_valid && (tmr == TMR_W'(TRES - 1));
  assign latch_done   = (state == LATCH) && (tmr == TMR_W'(TRES - 1));
  assign last_bit     = (bit_idx == BIX_W'(WORD_W - 1));
  assign bit_adv      = (state == SHIFT) && enc_done && !last_bit;

  // word_q holds the not-yet-launched bits left-aligned: the MSB goes straight
  // from data to the encoder on the handshake, so the stored copy is pre-shifted.
  assign enc_start = hs || bit_adv;
  assign enc_bit   = hs ? data[WORD_W-1] : word_q[WORD_W-1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req != 2'b00) state_nxt = ARB;
      ARB:   state_nxt = LOAD;
      LOAD:  if (hs) state_nxt = SHIFT;
             else if (load_timeout) state_nxt = LATCH;
      SHIFT: if (enc_done && last_bit) state_nxt = last_q ? LATCH : LOAD;
      LATCH: if (latch_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_q      <= '0;
      last_srv   <= 1'b1;
      grant      <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      bit_idx    <= '0;
      tmr        <= '0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      underrun_q <= load_timeout;
      if (state == IDLE) req_q <= req;
      if (state == ARB) begin
        grant    <= winner ? 2'b10 : 2'b01;
        last_srv <= winner;
      end else if (latch_done) begin
        grant <= '0;
      end
      // Shared timer: LOAD underrun and LATCH gap, restarted on every state change.
      if (state != state_nxt)                     tmr <= '0;
      else if (state == LOAD || state == LATCH)   tmr <= tmr + 1'b1;
      if (hs) begin
        word_q  <= {data[WORD_W-2:0], 1'b0};
        last_q  <= data_last;
        bit_idx <= '0;
      end else if (bit_adv) begin
        word_q  <= {word_q[WORD_W-2:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  trainled_bit_enc #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_bit_enc (
    .clk     (clk),
    .rst     (rst),
    .start   (enc_start),
    .bit_val (enc_bit),
    .pulse   (enc_pulse),
    .done    (enc_done)
  );

  assign dout       = grant & {2{enc_pulse}};
  assign data_ready = (state == LOAD);
  assign busy       = (state != IDLE);
  assign underrun   = underrun_q;

`ifdef TRAINLED_FRAME_CNT_EN
  logic            aborted;
  logic [1:0][15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aborted     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (state == ARB)       aborted <= 1'b0;
      else if (load_timeout)  aborted <= 1'b1;
      if (latch_done && !aborted)
        frame_cnt_q[last_srv] <= frame_cnt_q[last_srv] + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_trainled_chain_ctrl.sv
// Self-checking bench for trainled_chain_ctrl. A frame-level reference model
// expands each requested frame into the expected per-cycle output trace and the
// per-cycle input drive; each test task compares the captured trace against it.
// Define TRAINLED_FRAME_CNT_EN to also exercise the frame counters.
module tb_trainled_chain_ctrl;

  localparam int WW      = 24;
  localparam int TB_TBIT = 16;
  localparam int TB_T0H  = 4;
  localparam int TB_T1H  = 12;
  localparam int TB_TRES = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    grant;
  logic [WW-1:0] data = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          data_last = 1'b0;
  logic [1:0]    dout;
  logic          busy;
  logic          underrun;
`ifdef TRAINLED_FRAME_CNT_EN
  logic [1:0][15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  trainled_chain_ctrl #(
    .WORD_W (WW),
    .TBIT   (TB_TBIT),
    .T0H    (TB_T0H),
    .T1H    (TB_T1H),
    .TRES   (TB_TRES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last),
    .dout       (dout),
    .busy       (busy),
    .underrun   (underrun)
`ifdef TRAINLED_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  typedef struct packed {
    logic          valid;
    logic          last;
    logic [WW-1:0] data;
  } drv_t;
  // {grant[1:0], dout[1:0], data_ready, busy, underrun}
  typedef logic [6:0] snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  drv_t  drv_q[$];

  int checks = 0;
  int errors = 0;
  int last_served = 1;
  int frame_chain;
  bit frame_aborted;
  logic [15:0] exp_cnt [2];

  function automatic snap_t mk(logic [1:0] g, logic [1:0] d, logic r, logic b, logic u);
    return {g, d, r, b, u};
  endfunction

  function automatic drv_t mkd(logic v, logic l, logic [WW-1:0] w);
    return {v, l, w};
  endfunction

  function automatic drv_t junk();
    return mkd(1'b0, 1'($urandom_range(1, 0)), WW'($urandom));
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Reference model: expected trace from the ARB cycle to the first IDLE cycle
  // after the frame, plus the input drive for each of those cycles.
  task automatic build_frame(input logic [1:0] rq, input int nw, input int under_at,
                             input bit hold, input int maxd, input bit fix0,
                             input logic [WW-1:0] w0);
    logic [WW-1:0] w [4];
    logic [1:0]    g;
    int            d;
    exp_q.delete();
    drv_q.delete();
    frame_aborted = 1'b0;
    if (rq == 2'b11) frame_chain = 1 - last_served;
    else             frame_chain = (rq == 2'b10) ? 1 : 0;
    last_served = frame_chain;
    g = (frame_chain == 1) ? 2'b10 : 2'b01;
    for (int i = 0; i < 4; i++) w[i] = WW'($urandom);
    if (fix0) w[0] = w0;
    exp_q.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    drv_q.push_back(mkd(hold, 1'(nw == 1), w[0]));
    for (int i = 0; i < nw; i++) begin
      d = (i == under_at) ? TB_TRES : (hold ? 0 : int'($urandom_range(maxd, 0)));
      repeat (d) begin
        exp_q.push_back(mk(g, 2'b00, 1'b1, 1'b1, 1'b0));
        drv_q.push_back(junk());
      end
      if (i == under_at) begin
        frame_aborted = 1'b1;
        break;
      end
      exp_q.push_back(mk(g, 2'b00, 1'b1, 1'b1, 1'b0));
      drv_q.push_back(mkd(1'b1, 1'(i == nw - 1), w[i]));
      for (int b = WW - 1; b >= 0; b--) begin
        for (int k = 0; k < TB_TBIT; k++) begin
          exp_q.push_back(mk(g, (k < (w[i][b] ? TB_T1H : TB_T0H)) ? g : 2'b00,
                             1'b0, 1'b1, 1'b0));
          if (hold && i + 1 < nw) drv_q.push_back(mkd(1'b1, 1'(i + 1 == nw - 1), w[i+1]));
          else                    drv_q.push_back(junk());
        end
      end
    end
    for (int k = 0; k < TB_TRES; k++) begin
      exp_q.push_back(mk(g, 2'b00, 1'b0, 1'b1, 1'(frame_aborted && k == 0)));
      drv_q.push_back(junk());
    end
    exp_q.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    drv_q.push_back(junk());
    if (!frame_aborted) exp_cnt[frame_chain] = exp_cnt[frame_chain] + 16'd1;
  endtask

  // Entered and left at a negedge of an IDLE cycle; captures outputs and drives
  // inputs once per cycle for the length of the modelled frame.
  task automatic run_frame(input logic [1:0] rq, input bit drop);
    obs_q.delete();
    req = rq;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs_q.push_back({grant, dout, data_ready, busy, underrun});
      data_valid = drv_q[i].valid;
      data_last  = drv_q[i].last;
      data       = drv_q[i].data;
      if (drop && i == 0) req = 2'($urandom_range(3, 0));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    data_valid = 1'b0;
    data_last = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_served = 1;
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b expected 00", grant); end
    checks++; if (dout !== 2'b00) begin errors++; $display("FAIL reset_dout got %b expected 00", dout); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", data_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b expected 0", underrun); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [3];
    int bad;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      build_frame(2'b11, 1, -1, 1'b0, 2, 1'b0, '0);
      run_frame(2'b11, 1'b0);
      checks++;
      if (obs_q[1][6:5] !== exp_g[f]) begin
        errors++; $display("FAIL contention_grant frame %0d got %b expected %b", f, obs_q[1][6:5], exp_g[f]);
      end
      bad = first_diff();
      checks++;
      if (bad >= 0) begin
        errors++; $display("FAIL contention_trace frame %0d cycle %0d got %b expected %b", f, bad, obs_q[bad], exp_q[bad]);
      end
    end
  endtask

  task automatic test_single_frame();
    int n0, n1, rel, bad;
    bit d1;
    build_frame(2'b01, 1, -1, 1'b0, 0, 1'b1, 24'hA50000);
    run_frame(2'b01, 1'b0);
    n0 = 0; n1 = 0; d1 = 1'b0; rel = -1;
    for (int i = 2; i < 18; i++) n0 += int'(obs_q[i][3]);
    for (int i = 18; i < 34; i++) n1 += int'(obs_q[i][3]);
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i][4]) d1 = 1'b1;
      if (i > 1 && rel < 0 && obs_q[i][6:5] == 2'b00) rel = i;
    end
    checks++; if (n0 !== 12) begin errors++; $display("FAIL single_bit0_high got %0d expected 12", n0); end
    checks++; if (n1 !== 4) begin errors++; $display("FAIL single_bit1_high got %0d expected 4", n1); end
    checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL single_dout1_quiet got %b expected 0", d1); end
    checks++; if (rel !== 2 + 384 + 256) begin errors++; $display("FAIL single_release got %0d expected %0d", rel, 2 + 384 + 256); end
    bad = first_diff();
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL single_trace cycle %0d got %b expected %b", bad, obs_q[bad], exp_q[bad]); end
  endtask

  task automatic test_back_to_back();
    int nready, s, r, bad;
    build_frame(2'b01, 3, -1, 1'b1, 0, 1'b0, '0);
    run_frame(2'b01, 1'b0);
    nready = 0; s = -1; r = -1;
    for (int i = 0; i < obs_q.size(); i++) begin
      nready += int'(obs_q[i][2]);
      if (s < 0 && obs_q[i][4:3] != 2'b00) s = i;
      if (s >= 0 && r < 0 && obs_q[i][6:5] == 2'b00) r = i;
    end
    checks++; if (nready !== 3) begin errors++; $display("FAIL b2b_ready_count got %0d expected 3", nready); end
    checks++; if (r - s !== 3 * 384 + 2 + 256) begin errors++; $display("FAIL b2b_frame_len got %0d expected %0d", r - s, 3 * 384 + 2 + 256); end
    bad = first_diff();
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL b2b_trace cycle %0d got %b expected %b", bad, obs_q[bad], exp_q[bad]); end
  endtask

  task automatic test_underrun();
    int npulse, bad;
    build_frame(2'b10, 2, 1, 1'b0, 1, 1'b0, '0);
    run_frame(2'b10, 1'b0);
    npulse = 0;
    for (int i = 0; i < obs_q.size(); i++) npulse += int'(obs_q[i][0]);
    checks++; if (npulse !== 1) begin errors++; $display("FAIL underrun_pulses got %0d expected 1", npulse); end
    bad = first_diff();
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL underrun_trace cycle %0d got %b expected %b", bad, obs_q[bad], exp_q[bad]); end
`ifdef TRAINLED_FRAME_CNT_EN
    checks++;
    if (frame_cnt[1] !== exp_cnt[1]) begin errors++; $display("FAIL underrun_cnt got %h expected %h", frame_cnt[1], exp_cnt[1]); end
`endif
  endtask

  task automatic test_random();
    logic [1:0] rq;
    bit hold;
    int bad;
    for (int f = 0; f < 6; f++) begin
      rq   = 2'($urandom_range(3, 1));
      hold = 1'($urandom_range(1, 0));
      build_frame(rq, int'($urandom_range(3, 1)), -1, hold, 3, 1'b0, '0);
      run_frame(rq, 1'($urandom_range(1, 0)));
      bad = first_diff();
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL random_trace frame %0d cycle %0d got %b expected %b", f, bad, obs_q[bad], exp_q[bad]); end
`ifdef TRAINLED_FRAME_CNT_EN
      checks++;
      if (frame_cnt !== {exp_cnt[1], exp_cnt[0]}) begin
        errors++; $display("FAIL random_cnt frame %0d got %h expected %h", f, frame_cnt, {exp_cnt[1], exp_cnt[0]});
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    int bad;
    req = 2'b01;
    data_valid = 1'b1;
    data_last = 1'b1;
    data = '1;
    repeat (38) @(negedge clk);
    checks++; if (dout !== 2'b01) begin errors++; $display("FAIL areset_pre_dout got %b expected 01", dout); end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++; if (dout !== 2'b00) begin errors++; $display("FAIL areset_dout got %b expected 00", dout); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL areset_grant got %b expected 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b expected 0", busy); end
    @(negedge clk);
    req = 2'b11;
    data_valid = 1'b0;
    last_served = 1;
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
    @(negedge clk);
    rst = 1'b1;
    build_frame(2'b11, 1, -1, 1'b0, 1, 1'b0, '0);
    run_frame(2'b11, 1'b0);
    checks++; if (obs_q[1][6:5] !== 2'b01) begin errors++; $display("FAIL areset_rr_grant got %b expected 01", obs_q[1][6:5]); end
    bad = first_diff();
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL areset_trace cycle %0d got %b expected %b", bad, obs_q[bad], exp_q[bad]); end
  endtask

`ifdef TRAINLED_FRAME_CNT_EN
  task automatic test_frame_cnt_wrap();
    dut.frame_cnt_q[0] = 16'hFFFF;
    exp_cnt[0] = 16'hFFFF;
    build_frame(2'b01, 1, -1, 1'b0, 1, 1'b0, '0);
    run_frame(2'b01, 1'b0);
    checks++; if (frame_cnt[0] !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got %h expected 0000", frame_cnt[0]); end
    checks++; if (frame_cnt[1] !== exp_cnt[1]) begin errors++; $display("FAIL cnt_other got %h expected %h", frame_cnt[1], exp_cnt[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_random();
`ifdef TRAINLED_FRAME_CNT_EN
    test_frame_cnt_wrap();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
